// File: rtl/sd_cmd_sender.sv
// SD card SPI-mode command sender: frames a 6-byte command, then polls with 0xFF until R1 arrives or MAX_POLL expires.
// Optional macro SD_CMD_CRC_EN computes the real CRC7; otherwise only the CMD0/CMD8 CRCs are supplied.
//
// state        | meaning
// -------------|--------------------------------------------------------------
// S_IDLE       | waiting for start, cs_n high
// S_ISSUE      | presenting frame byte, spi_execute high until engine reports busy
// S_WAIT       | frame byte in flight, advance on spi_finished
// S_POLL_ISSUE | presenting 0xFF poll byte, spi_execute high until engine busy
// S_POLL_WAIT  | poll byte in flight, inspect received byte on spi_finished
// S_DONE       | one-cycle completion, cs_n released

module sd_cmd_sender #(
  parameter int MAX_POLL = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  output logic        busy,
  output logic        done,
  output logic [7:0]  r1,
  output logic        timeout,
  output logic        cs_n,
  output logic        spi_execute,
  output logic [7:0]  spi_out_word,
  input  logic [7:0]  spi_in_word,
  input  logic        spi_finished,
  input  logic        spi_busy
);

  localparam int PW = (MAX_POLL > 1) ? $clog2(MAX_POLL) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_POLL_ISSUE,
    S_POLL_WAIT,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      byte_cnt_q, byte_cnt_d;
  logic [PW-1:0]   poll_cnt_q, poll_cnt_d;
  logic [5:0]      idx_q, idx_d;
  logic [31:0]     arg_q, arg_d;
  logic [7:0]      r1_q, r1_d;
  logic            timeout_q, timeout_d;
  logic [6:0]      crc7;
  logic [7:0]      frame_byte;

`ifdef SD_CMD_CRC_EN
  function automatic logic [6:0] crc7_calc(input logic [39:0] data);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = data[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  assign crc7 = crc7_calc({2'b01, idx_q, arg_q});
`else
  // Only the commands issued before CRC checking is switched off need a valid CRC.
  always_comb begin
    crc7 = 7'h00;
    case (idx_q)
      6'd0:    crc7 = 7'h4A;
      6'd8:    crc7 = 7'h43;
      default: crc7 = 7'h00;
    endcase
  end
`endif

  always_comb begin
    frame_byte = {crc7, 1'b1};
    case (byte_cnt_q)
      3'd0:    frame_byte = {2'b01, idx_q};
      3'd1:    frame_byte = arg_q[31:24];
      3'd2:    frame_byte = arg_q[23:16];
      3'd3:    frame_byte = arg_q[15:8];
      3'd4:    frame_byte = arg_q[7:0];
      default: frame_byte = {crc7, 1'b1};
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      byte_cnt_q <= '0;
      poll_cnt_q <= '0;
      idx_q      <= '0;
      arg_q      <= '0;
      r1_q       <= 8'hFF;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      poll_cnt_q <= poll_cnt_d;
      idx_q      <= idx_d;
      arg_q      <= arg_d;
      r1_q       <= r1_d;
      timeout_q  <= timeout_d;
    end
  end

  // Outputs decode from the state register so reset takes effect on them immediately.
  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    poll_cnt_d   = poll_cnt_q;
    idx_d        = idx_q;
    arg_d        = arg_q;
    r1_d         = r1_q;
    timeout_d    = timeout_q;
    busy         = 1'b0;
    done         = 1'b0;
    cs_n         = 1'b1;
    spi_execute  = 1'b0;
    spi_out_word = 8'hFF;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          idx_d      = cmd_index;
          arg_d      = cmd_arg;
          byte_cnt_d = '0;
          poll_cnt_d = '0;
          r1_d       = 8'hFF;
          timeout_d  = 1'b0;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        busy         = 1'b1;
        cs_n         = 1'b0;
        spi_execute  = 1'b1;
        spi_out_word = frame_byte;
        if (spi_busy) state_d = S_WAIT;
      end
      S_WAIT: begin
        busy         = 1'b1;
        cs_n         = 1'b0;
        spi_out_word = frame_byte;
        if (spi_finished) begin
          if (byte_cnt_q == 3'd5) begin
            poll_cnt_d = PW'(MAX_POLL - 1);
            state_d    = S_POLL_ISSUE;
          end else begin
            byte_cnt_d = byte_cnt_q + 3'd1;
            state_d    = S_ISSUE;
          end
        end
      end
      S_POLL_ISSUE: begin
        busy         = 1'b1;
        cs_n         = 1'b0;
        spi_execute  = 1'b1;
        spi_out_word = 8'hFF;
        if (spi_busy) state_d = S_POLL_WAIT;
      end
      S_POLL_WAIT: begin
        busy = 1'b1;
        cs_n = 1'b0;
        if (spi_finished) begin
          if (!spi_in_word[7]) begin
            r1_d    = spi_in_word;
            state_d = S_DONE;
          end else if (poll_cnt_q == '0) begin
            r1_d      = 8'hFF;
            timeout_d = 1'b1;
            state_d   = S_DONE;
          end else begin
            poll_cnt_d = poll_cnt_q - 1'b1;
            state_d    = S_POLL_ISSUE;
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign r1      = r1_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_sd_cmd_sender.sv
// Directed bench for sd_cmd_sender with a behavioural byte-transfer engine and a scripted card response.
// Last-byte expectation for CMD55 follows SD_CMD_CRC_EN.

module tb_sd_cmd_sender;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        busy, done, timeout, cs_n, spi_execute;
  logic [7:0]  r1, spi_out_word;
  logic [7:0]  spi_in_word;
  logic        spi_finished;
  logic        spi_busy;

`ifdef SD_CMD_CRC_EN
  localparam logic [7:0] CMD55_LAST = 8'h65;
`else
  localparam logic [7:0] CMD55_LAST = 8'h01;
`endif

  sd_cmd_sender #(.MAX_POLL(8)) dut (
    .clk(clk), .reset(reset), .start(start), .cmd_index(cmd_index), .cmd_arg(cmd_arg),
    .busy(busy), .done(done), .r1(r1), .timeout(timeout), .cs_n(cs_n),
    .spi_execute(spi_execute), .spi_out_word(spi_out_word), .spi_in_word(spi_in_word),
    .spi_finished(spi_finished), .spi_busy(spi_busy)
  );

  always #5 clk = ~clk;

  int         n_chk = 0;
  int         n_bad = 0;
  logic [7:0] log_b [0:511];
  int         log_n = 0;
  int         frm_base = 0;
  int         ans_at = 0;
  logic [7:0] ans_val = 8'h00;
  int         done_cnt = 0;
  int         done_base = 0;
  int         exec_viol = 0;
  logic       eng_busy = 1'b0;
  int         eng_cnt = 0;
  logic [7:0] eng_resp = 8'hFF;
  int         rel;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Engine: accepts spi_execute, stays busy three cycles, then pulses spi_finished.
  always @(negedge clk) begin
    spi_finished = 1'b0;
    if (spi_execute && eng_busy) exec_viol++;
    if (reset) begin
      eng_busy = 1'b0;
      spi_busy = 1'b0;
    end else if (eng_busy) begin
      if (eng_cnt > 0) eng_cnt--;
      else begin
        spi_busy     = 1'b0;
        spi_finished = 1'b1;
        spi_in_word  = eng_resp;
        eng_busy     = 1'b0;
      end
    end else if (spi_execute) begin
      log_b[log_n] = spi_out_word;
      rel = log_n - frm_base;
      eng_resp = (rel >= 6 && ans_at > 0 && (rel - 5) >= ans_at) ? ans_val : 8'hFF;
      log_n++;
      eng_busy = 1'b1;
      spi_busy = 1'b1;
      eng_cnt  = 2;
    end
  end

  always @(posedge clk) if (done) done_cnt++;

  task automatic start_cmd(input logic [5:0] idx, input logic [31:0] arg,
                           input int at, input logic [7:0] val);
    frm_base  = log_n;
    done_base = done_cnt;
    ans_at    = at;
    ans_val   = val;
    cmd_index = idx;
    cmd_arg   = arg;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1'b1);
    chk("cs_low_after_start", cs_n, 1'b0);
    chk("timeout_cleared", timeout, 1'b0);
  endtask

  task automatic wait_done(input logic [7:0] exp_r1, input logic exp_to);
    int i;
    i = 0;
    while (!done && i < 500) begin
      @(negedge clk);
      i++;
    end
    chk("done_seen", done, 1'b1);
    chk("busy_at_done", busy, 1'b0);
    chk("cs_high_at_done", cs_n, 1'b1);
    chk("r1", r1, exp_r1);
    chk("timeout", timeout, exp_to);
    @(negedge clk);
    chk("done_one_cycle", done, 1'b0);
    chk("r1_held", r1, exp_r1);
    repeat (3) @(negedge clk);
    chk("done_pulses", done_cnt - done_base, 1);
  endtask

  task automatic check_frame(input logic [47:0] hdr, input int npoll);
    chk("nbytes", log_n - frm_base, 6 + npoll);
    for (int i = 0; i < 6; i++) chk($sformatf("byte%0d", i), log_b[frm_base + i], hdr[8*(5-i) +: 8]);
    for (int i = 6; i < 6 + npoll; i++) chk($sformatf("poll%0d", i - 6), log_b[frm_base + i], 8'hFF);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "time limit");
  end

  initial begin
    int i;
    reset = 1'b1; start = 1'b0; cmd_index = '0; cmd_arg = '0;
    spi_in_word = 8'hFF; spi_finished = 1'b0; spi_busy = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_timeout", timeout, 1'b0);
    chk("rst_r1", r1, 8'hFF);
    chk("rst_cs_n", cs_n, 1'b1);
    chk("rst_exec", spi_execute, 1'b0);
    chk("rst_out_word", spi_out_word, 8'hFF);
    reset = 1'b0;

    // CMD0, card answers 0x01 on second poll
    start_cmd(6'd0, 32'h0, 2, 8'h01);
    wait_done(8'h01, 1'b0);
    check_frame(48'h40_00_00_00_00_95, 2);

    // CMD8 with voltage-check argument
    start_cmd(6'd8, 32'h0000_01AA, 1, 8'h01);
    wait_done(8'h01, 1'b0);
    check_frame(48'h48_00_00_01_AA_87, 1);

    // CMD55, answer 0x00 on third poll
    start_cmd(6'd55, 32'h0, 3, 8'h00);
    wait_done(8'h00, 1'b0);
    check_frame({40'h77_00_00_00_00, CMD55_LAST}, 3);

    // Card never answers
    start_cmd(6'd0, 32'h0, 0, 8'h00);
    wait_done(8'hFF, 1'b1);
    check_frame(48'h40_00_00_00_00_95, 8);

    // Next start clears timeout; card reports illegal command 0x05
    start_cmd(6'd8, 32'h0000_01AA, 1, 8'h05);
    wait_done(8'h05, 1'b0);
    check_frame(48'h48_00_00_01_AA_87, 1);

    // Reset during byte 3 of CMD8
    start_cmd(6'd8, 32'h0000_01AA, 1, 8'h01);
    i = 0;
    while ((log_n - frm_base) < 4 && i < 200) begin
      @(negedge clk);
      i++;
    end
    chk("reached_byte3", log_n - frm_base, 4);
    #2 reset = 1'b1;
    #1;
    chk("midrst_exec", spi_execute, 1'b0);
    chk("midrst_cs_n", cs_n, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_out_word", spi_out_word, 8'hFF);
    chk("midrst_r1", r1, 8'hFF);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    start_cmd(6'd0, 32'h0, 1, 8'h01);
    wait_done(8'h01, 1'b0);
    check_frame(48'h40_00_00_00_00_95, 1);

    // Start during a transfer must be ignored
    start_cmd(6'd0, 32'h0, 1, 8'h01);
    i = 0;
    while ((log_n - frm_base) < 2 && i < 200) begin
      @(negedge clk);
      i++;
    end
    cmd_index = 6'd8;
    cmd_arg   = 32'hDEAD_BEEF;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(8'h01, 1'b0);
    check_frame(48'h40_00_00_00_00_95, 1);

    chk("exec_while_engine_busy", exec_viol, 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/sd_cmd_sender.md
SD_CMD_SENDER -- requirements
Module: sd_cmd_sender

Interface
REQ-001 SHALL have parameter MAX_POLL, default 8, the maximum number of 0xFF poll bytes sent while waiting for R1.
REQ-002 SHALL have one clock and an asynchronous, active-high reset; ports are clk and reset.
REQ-003 SHALL have ports: clk  in  1  system clock, all logic on rising edge.
REQ-004 SHALL have ports: reset  in  1  asynchronous active-high reset.
REQ-005 SHALL have ports: start  in  1  one-cycle request to issue a command.
REQ-006 SHALL have ports: cmd_index  in  6  SD command number.
REQ-007 SHALL have ports: cmd_arg  in  32  command argument.
REQ-008 SHALL have ports: busy  out  1  high from accepted start until done.
REQ-009 SHALL have ports: done  out  1  one-cycle completion pulse.
REQ-010 SHALL have ports: r1  out  8  R1 response byte, valid from done until next start.
REQ-011 SHALL have ports: timeout  out  1  set with done when no R1 arrived.
REQ-012 SHALL have ports: cs_n  out  1  card chip select, active low.
REQ-013 SHALL have ports: spi_execute  out  1, spi_out_word  out  8, spi_in_word  in  8, spi_finished  in  1, spi_busy  in  1 (byte-transfer engine side).

Function
REQ-014 SHALL latch cmd_index and cmd_arg on start in IDLE; start while busy SHALL be ignored.
REQ-015 SHALL use states IDLE -> ISSUE -> WAIT -> (ISSUE, next byte | POLL_ISSUE after byte 5) ; POLL_ISSUE -> POLL_WAIT -> (POLL_ISSUE | DONE) ; DONE -> IDLE.
REQ-016 SHALL send frame bytes in order: {2'b01, cmd_index}, cmd_arg[31:24], [23:16], [15:8], [7:0], {crc7, 1'b1}.
REQ-017 ISSUE SHALL drive spi_out_word and hold spi_execute high until spi_busy is sampled high, then drop spi_execute and enter WAIT.
REQ-018 WAIT SHALL advance only on spi_finished; a byte counter 0..5 selects the frame byte.
REQ-019 POLL_ISSUE SHALL send 0xFF; on spi_finished, spi_in_word[7]==0 SHALL capture r1=spi_in_word and go to DONE.
REQ-020 After MAX_POLL poll bytes with bit7 high, SHALL go to DONE with timeout=1, r1=0xFF.
REQ-021 cs_n SHALL go low on the cycle start is accepted and return high in DONE.
REQ-022 done SHALL pulse exactly one cycle in DONE; busy SHALL fall in the same cycle.
REQ-023 spi_execute SHALL never be asserted while in WAIT, POLL_WAIT, IDLE or DONE.
REQ-024 timeout SHALL clear on the next accepted start.

Reset
REQ-025 Reset SHALL force IDLE, busy=0, done=0, timeout=0, r1=0xFF, cs_n=1, spi_execute=0, spi_out_word=0xFF, counters=0, asynchronously, including mid-frame.
REQ-026 After reset release, the first start SHALL be accepted on the next rising edge.

Configuration
REQ-027 Macro SD_CMD_CRC_EN defined: crc7 SHALL be computed (polynomial x^7+x^3+1, init 0) over the first five frame bytes.
REQ-028 SD_CMD_CRC_EN undefined: crc7 SHALL be 7'h4A for cmd_index 0, 7'h43 for cmd_index 8, else 7'h00 (last byte 0x95, 0x87, 0x01).

Verification
REQ-029 CMD0, arg 0, card answers 0x01 on second poll -> bytes 40 00 00 00 00 95 FF FF, r1=0x01, timeout=0, one done pulse.
REQ-030 CMD8, arg 0x000001AA -> bytes 48 00 00 01 AA 87; with SD_CMD_CRC_EN, CMD55 arg 0 -> last byte 0x65.
REQ-031 Card returns 0xFF always, MAX_POLL=8 -> exactly 8 poll bytes, done with timeout=1, r1=0xFF, cs_n=1.
REQ-032 reset asserted during byte 3 -> same-cycle spi_execute=0, cs_n=1, busy=0; next start sends full frame from byte 0.
REQ-033 start pulsed during WAIT with different cmd_index -> ignored; frame bytes unchanged, single done.
